pipe_stage_buf: RTL and testbench

- Parametrised pipeline-boundary register, the successor to the fixed stage latches (EX/MEM, MEM/WB).
- Carries a DW-bit payload with a valid/ready handshake.
- Holds a 2-entry skid buffer, so backpressure never needs a combinational path from dn_ready to up_ready.
- Supports a global rdy freeze and a synchronous flush (bubble insertion) in place of the stall_ctrler bit pairs.

---
 rtl/pipe_stage_buf.sv | 83 ++++++++
 tb/tb_pipe_stage_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with 2-entry skid buffer, rdy freeze and flush.
// Define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt output.
module pipe_stage_buf #(
    parameter int DW = 38,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          flush,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [DW-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
    logic          acc, snd;

    // up_ready depends only on registered state, never on dn_ready
    assign up_ready = rst_n & rdy & ~flush & ~skid_v_q;
    assign dn_valid = rdy & main_v_q;
    assign dn_data  = main_d_q;
    assign acc      = up_valid & up_ready;
    assign snd      = dn_valid & dn_ready;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (rdy && flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d_d = RST_VAL;
            skid_d_d = RST_VAL;
        end else if (!main_v_q) begin
            main_v_d = acc;
            main_d_d = acc ? up_data : main_d_q;
        end else if (!skid_v_q) begin
            main_v_d = acc | ~snd;
            main_d_d = (acc && snd) ? up_data : main_d_q;
            skid_v_d = acc & ~snd;
            skid_d_d = (acc && !snd) ? up_data : skid_d_q;
        end else if (snd) begin
            skid_v_d = 1'b0;
            main_d_d = skid_d_q;
            skid_d_d = RST_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= RST_VAL;
            skid_d_q <= RST_VAL;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + {31'b0, rdy & main_v_q & ~dn_ready};
    assign stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 32'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks of pipe_stage_buf against a queue-based model.
module tb_pipe_stage_buf;
    localparam int DW = 38;
    localparam logic [DW-1:0] RV = '0;

    logic          clk = 1'b0, rst_n = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic          up_valid = 1'b0, dn_ready = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          up_ready, dn_valid;
    logic [DW-1:0] dn_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    pipe_stage_buf #(.DW(DW), .RST_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most 2 entries; dn_data shows the head,
    // or the most recently popped head once drained (RST_VAL after reset/flush).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] last = RV;
    int unsigned   m_stall = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            last = RV;
            m_stall = 0;
        end else if (rdy) begin
            bit pop, push;
            if (mq.size() > 0 && !dn_ready) m_stall++;
            if (flush) begin
                mq.delete();
                last = RV;
            end else begin
                push = up_valid && mq.size() < 2;
                pop  = mq.size() > 0 && dn_ready;
                if (pop) last = mq.pop_front();
                if (push) mq.push_back(up_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("dn_valid", 64'(dn_valid), 64'(rst_n && rdy && mq.size() > 0));
        chk("dn_data", 64'(dn_data), 64'(mq.size() > 0 ? mq[0] : last));
        chk("up_ready", 64'(up_ready), 64'(rst_n && rdy && !flush && mq.size() < 2));
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic dr, input logic r, input logic f);
        up_valid = v; up_data = d; dn_ready = dr; rdy = r; flush = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // streaming
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_up_ready", 64'(up_ready), 64'd1);
            if (i > 1) begin
                chk("stream_valid", 64'(dn_valid), 64'd1);
                chk("stream_data", 64'(dn_data), 64'(i - 1));
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("stream_last", 64'(dn_data), 64'd4);
        tick();

        // backpressure
        drive(1'b1, DW'(8'hA), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, DW'(8'hB), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_up_ready", 64'(up_ready), 64'd0);
        chk("bp_hold", 64'(dn_data), 64'hA);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_pop_a", 64'(dn_data), 64'hA);
        tick();
        @(negedge clk);
        chk("bp_pop_b", 64'(dn_data), 64'hB);
        chk("bp_ready_back", 64'(up_ready), 64'd1);
        tick();

        // flush while FULL
        drive(1'b1, DW'(8'hA), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, DW'(8'hB), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, DW'(8'hC), 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush_up_ready", 64'(up_ready), 64'd0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_valid", 64'(dn_valid), 64'd0);
        chk("flush_data", 64'(dn_data), 64'(RV));
        drive(1'b1, DW'(8'hD), 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_after_d", 64'(dn_data), 64'hD);
        chk("flush_after_v", 64'(dn_valid), 64'd1);
        tick();

        // rdy freeze
        drive(1'b1, DW'(5), 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(9), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("freeze_valid", 64'(dn_valid), 64'd0);
            chk("freeze_ready", 64'(up_ready), 64'd0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("freeze_out", 64'(dn_data), 64'd5);
        chk("freeze_out_v", 64'(dn_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("freeze_once", 64'(dn_valid), 64'd0);
        tick();

        // async reset while FULL
        drive(1'b1, DW'(8'h11), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, DW'(8'h22), 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(dn_valid), 64'd0);
        chk("rst_data", 64'(dn_data), 64'd0);
        chk("rst_up_ready", 64'(up_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, DW'(7), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_release_ready", 64'(up_ready), 64'd1);
        tick();

        // stall counting: 7 stalled cycles, 2 frozen
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, 1'b0, !(i == 2 || i == 3), 1'b0);
            tick();
        end
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1); tick();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0); tick();
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_cnt_flush", 64'(stall_cnt), 64'd5);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), {6'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 29) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
